// File: rtl/uart_defs_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, byte width and
// the constant clog2 helper.
package uart_defs_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  function automatic int CLOG2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the serializer.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_defs_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [UART_BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           tx_valid;
  logic [UART_BYTE_W-1:0]         tx_data;
  logic                           tx_ready;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping.
module uart_rr_pick
  import uart_defs_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [CLOG2(NUM_REQ)-1:0] ptr,
  output logic                      any,
  output logic [CLOG2(NUM_REQ)-1:0] idx
);

  localparam int IDW = CLOG2(NUM_REQ);

  logic [IDW-1:0] cand_s;
  logic           hit_s;

  // Scan outward from ptr; the first hit wins and later candidates are masked.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = IDW'((int'(ptr) + k) % NUM_REQ);
      hit_s  = !any && req[cand_s];
      idx    = hit_s ? cand_s : idx;
      any    = any | hit_s;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter feeding one UART byte serializer
// through a one-entry output register.
module uart_tx_arbiter
  import uart_defs_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic                      clk,
  input  logic                      resetn,
  uart_tx_arbiter_if.slave          bus,
  output logic [CLOG2(NUM_REQ)-1:0] grant_id,
  output logic                      busy,
  output logic                      timeout
);

  localparam int IDW = CLOG2(NUM_REQ);
  localparam int TW  = CLOG2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q;
  logic [IDW-1:0]         grant_q;
  logic [IDW-1:0]         rr_ptr_q;
  logic                   busy_q;
  logic                   timeout_q;
  logic [TW-1:0]          timer_q;
  logic                   tx_valid_q;
  logic [UART_BYTE_W-1:0] tx_data_q;

  logic                   pick_any_s;
  logic [IDW-1:0]         pick_idx_s;
  logic [NUM_REQ-1:0]     req_ready_s;
  logic                   own_valid_s;
  logic                   own_last_s;
  logic [UART_BYTE_W-1:0] own_data_s;
  logic                   accept_s;
  logic [IDW-1:0]         next_ptr_s;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Owner's handshake view; the output register refills in the cycle it drains.
  always_comb begin
    own_valid_s = bus.req_valid[grant_q];
    own_last_s  = bus.req_last[grant_q];
    own_data_s  = bus.req_data[{grant_q, 3'b000} +: UART_BYTE_W];
    req_ready_s = '0;
    if (state_q == ST_OWN) begin
      req_ready_s[grant_q] = !tx_valid_q || bus.tx_ready;
    end else begin
      req_ready_s = '0;
    end
    accept_s   = own_valid_s && req_ready_s[grant_q];
    next_ptr_s = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);
  end

  // Arbitration FSM, idle timer, round-robin pointer and output register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      timer_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      timeout_q <= 1'b0;
      if (accept_s) begin
        tx_data_q  <= own_data_s;
        tx_valid_q <= 1'b1;
      end else if (tx_valid_q && bus.tx_ready) begin
        tx_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (pick_any_s) begin
            state_q <= ST_OWN;
            grant_q <= pick_idx_s;
            busy_q  <= 1'b1;
          end
        end
        ST_OWN: begin
          if (accept_s) begin
            timer_q <= '0;
            if (own_last_s) begin
              state_q  <= ST_IDLE;
              busy_q   <= 1'b0;
              rr_ptr_q <= next_ptr_s;
            end
          end else if (!own_valid_s) begin
            // Only a silent owner ages; a stalled owner is never revoked.
            if (timer_q == TIMER_LAST) begin
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
              rr_ptr_q  <= next_ptr_s;
              timeout_q <= 1'b1;
              timer_q   <= '0;
            end else if (timer_q != '1) begin
              timer_q <= timer_q + TW'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a byte/grant scoreboard.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       resetn;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests  = 0;
  int         failed = 0;
  logic [7:0] exp_q[$];
  int         exp_grant[$];
  logic [7:0] src_data [4][8];
  logic       src_last [4][8];
  int         src_len [4];
  int         src_pos [4];
  logic [3:0] acc_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_pos[i] < src_len[i]) begin
        bus.req_valid[i]         = 1'b1;
        bus.req_data[i*8 +: 8]   = src_data[i][src_pos[i]];
        bus.req_last[i]          = src_last[i][src_pos[i]];
      end else begin
        bus.req_valid[i]         = 1'b0;
        bus.req_data[i*8 +: 8]   = 8'h00;
        bus.req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic load(input int id, input logic [7:0] d, input logic l);
    src_data[id][src_len[id]] = d;
    src_last[id][src_len[id]] = l;
    src_len[id]++;
    exp_q.push_back(d);
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    exp_q.delete();
    exp_grant.delete();
    drive();
  endtask

  // One clock: sample handshakes at negedge, advance requesters after the edge.
  task automatic step();
    logic       prev_busy;
    logic [3:0] acc;
    @(negedge clk);
    prev_busy = busy;
    acc = bus.req_valid & bus.req_ready;
    if (bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() > 0) check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      else check("tx_unexpected", 32'(bus.tx_data), 32'hFFFF_FFFF);
    end
    @(posedge clk);
    #1;
    acc_last = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[i] && src_pos[i] < src_len[i]) src_pos[i]++;
    end
    drive();
    if (busy && !prev_busy) begin
      if (exp_grant.size() > 0) check("grant_order", 32'(grant_id), 32'(exp_grant.pop_front()));
      else check("grant_unexpected", 32'(grant_id), 32'hFF);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn       = 1'b0;
    bus.tx_ready = 1'b1;
    acc_last     = 4'h0;
    clear_all();

    // Reset with all four requesters already holding messages
    load(0, 8'h10, 1'b0); load(0, 8'h11, 1'b1);
    load(1, 8'h20, 1'b0); load(1, 8'h21, 1'b1);
    load(2, 8'h30, 1'b0); load(2, 8'h31, 1'b1);
    load(3, 8'h40, 1'b0); load(3, 8'h41, 1'b1);
    load(0, 8'h12, 1'b0); load(0, 8'h13, 1'b1);
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    resetn = 1'b1;
    exp_grant = '{0, 1, 2, 3, 0};
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin step(); n++; end
    step();
    check("cont_drained", 32'(exp_q.size()), 32'd0);
    check("cont_grants_done", 32'(exp_grant.size()), 32'd0);

    // Single message from requester 0
    load(0, 8'h31, 1'b0); load(0, 8'h32, 1'b1);
    exp_grant.push_back(0);
    drive();
    step();
    check("single_busy", 32'(busy), 32'd1);
    check("single_grant", 32'(grant_id), 32'd0);
    check("single_ready", 32'(bus.req_ready), 32'h1);
    step();
    check("single_tx_valid", 32'(bus.tx_valid), 32'd1);
    check("single_tx_data", 32'(bus.tx_data), 32'h31);
    check("single_grant_mid", 32'(grant_id), 32'd0);
    step();
    check("single_busy_fall", 32'(busy), 32'd0);
    check("single_last_data", 32'(bus.tx_data), 32'h32);
    step();
    check("single_tx_idle", 32'(bus.tx_valid), 32'd0);
    check("single_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure on requester 1
    bus.tx_ready = 1'b0;
    load(1, 8'hA5, 1'b0); load(1, 8'h5A, 1'b0); load(1, 8'h77, 1'b1);
    exp_grant.push_back(1);
    drive();
    n = 0;
    do begin step(); n++; end while (!bus.tx_valid && n < 10);
    check("bp_valid", 32'(bus.tx_valid), 32'd1);
    for (int c = 0; c < 20; c++) begin
      step();
      check("bp_hold_valid", 32'(bus.tx_valid), 32'd1);
      check("bp_hold_data", 32'(bus.tx_data), 32'hA5);
      check("bp_ready_low", 32'(bus.req_ready), 32'h0);
    end
    bus.tx_ready = 1'b1;
    step();
    check("bp_nogap_valid", 32'(bus.tx_valid), 32'd1);
    check("bp_nogap_data", 32'(bus.tx_data), 32'h5A);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin step(); n++; end
    step();
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Timeout: requester 2 goes silent mid-message, requester 3 waits
    load(2, 8'hC2, 1'b0);
    load(3, 8'hD3, 1'b1);
    exp_grant = '{2, 3};
    drive();
    n = 0;
    do begin step(); n++; end while (!acc_last[2] && n < 10);
    check("to_accepted", 32'(acc_last[2]), 32'd1);
    n = 0;
    do begin step(); n++; end while (!timeout && n < 40);
    check("to_latency", 32'(n), 32'd16);
    check("to_busy_drop", 32'(busy), 32'd0);
    step();
    check("to_pulse_width", 32'(timeout), 32'd0);
    check("to_regrant_busy", 32'(busy), 32'd1);
    check("to_regrant_id", 32'(grant_id), 32'd3);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin step(); n++; end
    step();
    check("to_drained", 32'(exp_q.size()), 32'd0);

    // Async reset mid-message from requester 2 with the output register full
    load(1, 8'h61, 1'b1);
    load(2, 8'hE0, 1'b0); load(2, 8'hE1, 1'b0); load(2, 8'hE2, 1'b1);
    exp_grant = '{1, 2};
    drive();
    n = 0;
    do begin step(); n++; end while (!acc_last[2] && n < 30);
    bus.tx_ready = 1'b0;
    step();
    check("ar_pre_valid", 32'(bus.tx_valid), 32'd1);
    check("ar_pre_busy", 32'(busy), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_req_ready", 32'(bus.req_ready), 32'h0);
    clear_all();
    @(posedge clk);
    #1;
    resetn       = 1'b1;
    bus.tx_ready = 1'b1;
    load(0, 8'h70, 1'b1);
    load(3, 8'h73, 1'b1);
    exp_grant = '{0, 3};
    drive();
    step();
    check("ar_fresh_grant", 32'(grant_id), 32'd0);
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin step(); n++; end
    check("ar_drained", 32'(exp_q.size()), 32'd0);
    check("ar_grants_done", 32'(exp_grant.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
